// File: rtl/dmem_resp_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int DEPTH_DEF   = 32'sd64;
    localparam int LATENCY_DEF = 32'sd2;

    function automatic int idx_width(input int depth);
        return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
    endfunction

    localparam int IDX_W_DEF = idx_width(DEPTH_DEF);

endpackage

// File: rtl/dmem_responder_be_ram.sv
// DEPTH x 32 RAM: synchronous byte-lane writes, registered read that can be forced to zero.
module be_ram
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic          clr,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // byte-lane write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 32'sd0; k < 32'sd4; k++) begin
                if (be[k]) begin
                    mem_r[idx][32'sd8*k +: 8] <= wdata[32'sd8*k +: 8];
                end
            end
        end
    end

    // read register holds the last load result until the next load completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= mem_r[idx];
        end else if (clr) begin
            rdata_r <= 32'h0000_0000;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency load/store acknowledge with range checking.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_busy
);

    localparam int AW = idx_width(DEPTH);
    localparam int CW = $clog2(LATENCY + 32'sd1);

    state_e          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            accept_s;
    logic            we_r;
    logic [3:0]      be_r;
    logic [29:0]     widx_r;
    logic [31:0]     wdata_r;
    logic            acc_we_s;
    logic [3:0]      acc_be_s;
    logic [29:0]     acc_widx_s;
    logic [31:0]     acc_wdata_s;
    logic            in_range_s;
    logic            enter_ack_s;
    logic            ack_r, err_r, busy_r;
    logic            unused_s;

    assign unused_s = ^i_addr[1:0];

    // next-state and wait-counter logic
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req) begin
                    accept_s = 1'b1;
                    if (LATENCY == 32'sd1) begin
                        state_s = ACK;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CW'(LATENCY - 32'sd2);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = ACK;
                end else begin
                    cnt_s = cnt_r - CW'(32'd1);
                end
            end
            ACK:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // with LATENCY==1 the access happens on the accept edge, so use the live request
    always_comb begin
        if (state_r == IDLE) begin
            acc_we_s    = i_we;
            acc_be_s    = i_be;
            acc_widx_s  = i_addr[31:2];
            acc_wdata_s = i_wdata;
        end else begin
            acc_we_s    = we_r;
            acc_be_s    = be_r;
            acc_widx_s  = widx_r;
            acc_wdata_s = wdata_r;
        end
    end

    assign in_range_s  = (acc_widx_s < 30'(DEPTH));
    assign enter_ack_s = (state_s == ACK) && (state_r != ACK);

    // state, counter, request capture and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            we_r    <= 1'b0;
            be_r    <= 4'h0;
            widx_r  <= 30'h0;
            wdata_r <= 32'h0000_0000;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                we_r    <= i_we;
                be_r    <= i_be;
                widx_r  <= i_addr[31:2];
                wdata_r <= i_wdata;
            end
            ack_r  <= enter_ack_s;
            err_r  <= enter_ack_s & ~in_range_s;
            busy_r <= (state_s != IDLE);
        end
    end

    be_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (enter_ack_s & acc_we_s & in_range_s),
        .be    (acc_be_s),
        .re    (enter_ack_s & ~acc_we_s & in_range_s),
        .clr   (enter_ack_s & ~acc_we_s & ~in_range_s),
        .idx   (acc_widx_s[AW-1:0]),
        .wdata (acc_wdata_s),
        .rdata (o_rdata)
    );

    assign o_ack  = ack_r;
    assign o_err  = err_r;
    assign o_busy = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: one LATENCY=2 responder (index 0) and one LATENCY=1 responder (index 1).
module tb_dmem_responder;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        req   [2];
    logic        we_i  [2];
    logic [3:0]  be_i  [2];
    logic [31:0] addr_i[2];
    logic [31:0] wd_i  [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        busy  [2];
    logic [31:0] last_rd[2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst[0]), .i_req(req[0]), .i_we(we_i[0]), .i_be(be_i[0]),
        .i_addr(addr_i[0]), .i_wdata(wd_i[0]), .o_ack(ack[0]), .o_rdata(rdata[0]),
        .o_err(err[0]), .o_busy(busy[0])
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst[1]), .i_req(req[1]), .i_we(we_i[1]), .i_be(be_i[1]),
        .i_addr(addr_i[1]), .i_wdata(wd_i[1]), .o_ack(ack[1]), .o_rdata(rdata[1]),
        .o_err(err[1]), .o_busy(busy[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d actual=%h expected=%h (t=%0t)", name, d, act, exp, $time);
    endtask

    task automatic pop_check(input int d);
        exp_t e;
        if (qsize(d) == 0) begin
            n_total++;
            $display("FAIL unexpected_ack dut%0d actual=ack expected=no ack (t=%0t)", d, $time);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check("ack_cycle", d, 64'(cyc), 64'(e.cyc));
            check("err", d, 64'(err[d]), 64'(e.err));
            check("rdata", d, 64'(rdata[d]), 64'(e.rd));
        end
    endtask

    // monitor: every cycle, compare whatever the DUTs present
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d])
                check("reset_outputs", d, 64'({ack[d], err[d], busy[d], rdata[d]}), 64'h0);
            else if (ack[d])
                pop_check(d);
            else
                check("err_without_ack", d, 64'(err[d]), 64'h0);
        end
    end

    task automatic send(input int d, input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd, input bit push);
        exp_t e;
        @(posedge clk); #1;
        req[d] = 1'b1; we_i[d] = we; be_i[d] = be; addr_i[d] = addr; wd_i[d] = wd;
        if (push) begin
            e.cyc = cyc + lat(d);
            e.err = e_err;
            e.rd  = we ? last_rd[d] : e_rd;
            if (!we) last_rd[d] = e_rd;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 20; i++) begin
            if (qsize(d) == 0) break;
            @(posedge clk);
        end
        check("ack_outstanding", d, 64'(qsize(d)), 64'h0);
        if (d == 0) q0.delete();
        else        q1.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic issue(input int d, input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd, input bit poke);
        send(d, we, be, addr, wd, e_err, e_rd, 1'b1);
        if (poke) begin
            req[d] = 1'b1; we_i[d] = 1'b1; be_i[d] = 4'hF; addr_i[d] = 32'h0; wd_i[d] = 32'h0BAD_0BAD;
        end
        @(negedge clk);
        check("busy_after_accept", d, 64'(busy[d]), 64'h1);
        if (poke) begin
            @(posedge clk); #1;
            req[d] = 1'b0;
        end
        drain(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; req[d] = 1'b0; we_i[d] = 1'b1; be_i[d] = 4'hF;
            addr_i[d] = 32'h10; wd_i[d] = 32'hFFFF_FFFF; last_rd[d] = 32'h0;
        end
        // requests toggling while held in reset must be ignored
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            req[0] = ~req[0]; req[1] = ~req[1];
        end
        req[0] = 1'b0; req[1] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (2) @(posedge clk);

        // LATENCY=2 directed vectors
        issue(0, 1'b1, 4'hF, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0);
        issue(0, 1'b0, 4'h0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0);
        issue(0, 1'b1, 4'h1, 32'h10,  32'h0000_00AA, 1'b0, 32'h0,         1'b1);
        issue(0, 1'b0, 4'hF, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEAA, 1'b0);
        issue(0, 1'b1, 4'h0, 32'h10,  32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0);
        issue(0, 1'b0, 4'h0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEAA, 1'b0);
        issue(0, 1'b1, 4'hF, 32'h100, 32'h1234_5678, 1'b1, 32'h0,         1'b0);
        issue(0, 1'b0, 4'h0, 32'h100, 32'h0,         1'b1, 32'h0,         1'b0);
        issue(0, 1'b0, 4'h0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEAA, 1'b0);
        issue(0, 1'b1, 4'h6, 32'h13,  32'h1122_3344, 1'b0, 32'h0,         1'b0);
        issue(0, 1'b0, 4'h0, 32'h12,  32'h0,         1'b0, 32'hDE22_33AA, 1'b0);
        issue(0, 1'b1, 4'hF, 32'hFC,  32'hA5A5_A5A5, 1'b0, 32'h0,         1'b0);
        issue(0, 1'b0, 4'h0, 32'hFC,  32'h0,         1'b0, 32'hA5A5_A5A5, 1'b0);

        // LATENCY=1: a request every second cycle
        send(1, 1'b1, 4'hF, 32'h0,   32'h0102_0304, 1'b0, 32'h0,         1'b1);
        send(1, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 32'h0102_0304, 1'b1);
        send(1, 1'b1, 4'hF, 32'h4,   32'h5566_7788, 1'b0, 32'h0,         1'b1);
        send(1, 1'b0, 4'h0, 32'h4,   32'h0,         1'b0, 32'h5566_7788, 1'b1);
        send(1, 1'b0, 4'h0, 32'h200, 32'h0,         1'b1, 32'h0,         1'b1);
        drain(1);

        // reset during the WAIT of a store aborts it
        issue(0, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
        send(0, 1'b1, 4'hF, 32'h20, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
        #2;
        rst[0] = 1'b0;
        last_rd[0] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        repeat (4) @(posedge clk);
        issue(0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);

        check("queues_empty", 0, 64'(q0.size() + q1.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (slave) end of the core's data-memory request interface.
- Accepts single-cycle load/store requests from the processor's memory stage and serves them from an internal word-addressed RAM with byte enables.
- Returns a one-cycle acknowledge after a fixed, parameterised latency and signals out-of-range accesses.
- Replaces the zero-wait data memory when the pipeline is built with stall-on-memory support.

Parameters:
- DEPTH, 64: number of 32-bit words in the RAM; power of two, ≥2.
- LATENCY, 2: cycles from request acceptance to o_ack; integer ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- i_req  input  1  request strobe; single-cycle pulse, honoured only when o_busy=0.
- i_we  input  1  1 = store, 0 = load.
- i_be  input  4  byte-lane write enables; ignored for loads.
- i_addr  input  32  byte address; bits [1:0] ignored; word index = i_addr[31:2].
- i_wdata  input  32  store data.
- o_ack  output  1  one-cycle completion pulse.
- o_rdata  output  32  load data; valid while o_ack=1; held until the next load ack.
- o_err  output  1  qualifies o_ack: access was out of range.
- o_busy  output  1  request in flight; i_req is ignored while high.

Behaviour:
- Reset (rst=0, async): state=IDLE, o_ack=0, o_err=0, o_busy=0, o_rdata=0, wait counter=0. RAM contents are not cleared; they are undefined after power-up.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: o_busy=0. When i_req=1 at an edge, capture we/be/addr/wdata. If LATENCY==1, go to ACK; otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: o_busy=1. If cnt==0, go to ACK; otherwise decrement cnt.
  - ACK: o_busy=1, o_ack=1 for exactly one cycle, then unconditionally return to IDLE.
- Latency: request in cycle c0 gives o_ack high in cycle c(LATENCY). Maximum throughput is one request per LATENCY+1 cycles.
- Access is performed on the edge entering ACK:
  - Store, in range: write each byte lane k where i_be[k]=1; other lanes keep their old values. o_rdata is unchanged.
  - Load, in range: o_rdata = RAM[word index].
- Out of range (word index ≥ DEPTH):
  - o_err=1 during the ACK cycle.
  - Store is suppressed; the RAM is unchanged.
  - A load sets o_rdata=0.
- o_err is 0 whenever o_ack is 0.
- i_req high while o_busy=1 is dropped silently, with no state change and no latch. The requester gates on o_busy.
- Requests with i_be=0000 still complete normally: ack issued, no bytes written.
- Reset asserted mid-operation: the transaction is aborted, no ack is produced, and a pending store is not committed.

Decomposition:
- Package dmem_resp_pkg:
  - state enum (IDLE, WAIT, ACK);
  - default DEPTH and LATENCY constants;
  - a localparam helper for the word-index width, $clog2(DEPTH).
- Sub-module be_ram: DEPTH×32 synchronous-write RAM with 4 byte enables and registered read. It is instantiated once and driven by the FSM.

Test Plan:
- Reset: hold rst=0 with i_req toggling → o_ack=0, o_busy=0, o_err=0, o_rdata=0 throughout.
- Store then load (LATENCY=2): store 0xDEADBEEF, be=1111, addr 0x10 in c0 → o_ack in c2, o_busy high c1–c2. Load addr 0x10 in c3 → o_ack in c5 with o_rdata=0xDEADBEEF, o_err=0.
- Byte enables: store 0x000000AA, be=0001, addr 0x10 → subsequent load returns 0xDEADBEAA. Store be=0000 → ack issued, data unchanged.
- Out of range (DEPTH=64): store 0x12345678 to addr 0x100 → ack with o_err=1. Load 0x100 → o_rdata=0, o_err=1. Load 0x10 still returns 0xDEADBEAA.
- Busy drop and LATENCY=1: i_req pulse while o_busy=1 → no extra ack. With LATENCY=1, requests every second cycle each ack exactly one cycle later.
- Reset mid-store: drive rst=0 during WAIT of a store to 0x20 → no ack. After release, a load of 0x20 returns the prior value.
